// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared symbol codes, stage states and sizing for the bomb puzzle modules.
package bomb_pkg;

  localparam int DEF_SEQ_LEN = 8;

  localparam logic [2:0] SYM_LEFT  = 3'd0;
  localparam logic [2:0] SYM_RIGHT = 3'd1;
  localparam logic [2:0] SYM_UP    = 3'd2;
  localparam logic [2:0] SYM_DOWN  = 3'd3;
  localparam logic [2:0] SYM_A     = 3'd4;
  localparam logic [2:0] SYM_B     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_PLAY,
    ST_SOLVED,
    ST_FAIL
  } state_t;

  function automatic logic is_symbol(input logic [2:0] code);
    return code <= SYM_B;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic w_fb;
  assign w_fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= seed;
    else        q <= {q[14:0], w_fb};
  end

endmodule

// File: rtl/sequence_stage.sv
// rtl/sequence_stage.sv - generates a random symbol sequence, then scores player presses against it.
module sequence_stage
  import bomb_pkg::*;
#(
  parameter int          SEQ_LEN   = DEF_SEQ_LEN,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [2:0] btn_code,
  output logic [3:0] buttons [0:SEQ_LEN-1],
  output logic       busy,
  output logic       strike,
  output logic [1:0] strikes,
  output logic       solved,
  output logic       exploded
);

  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [2:0]      r_type [0:SEQ_LEN-1];
  logic            r_done [0:SEQ_LEN-1];
  logic [15:0]     w_lfsr;
  logic [2:0]      w_sym;
  logic            w_unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  assign w_sym         = w_lfsr[2:0];
  assign w_unused_lfsr = ^w_lfsr[15:3];

  for (genvar g = 0; g < SEQ_LEN; g++) begin : g_slot
    assign buttons[g] = {r_done[g], r_type[g]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      busy     <= 1'b0;
      strike   <= 1'b0;
      strikes  <= 2'd0;
      solved   <= 1'b0;
      exploded <= 1'b0;
      for (int i = 0; i < SEQ_LEN; i++) begin
        r_type[i] <= 3'd0;
        r_done[i] <= 1'b0;
      end
    end else begin
      strike <= 1'b0;
      // start outranks any simultaneous press, whatever the current state
      if (start) begin
        r_state  <= ST_GEN;
        r_idx    <= '0;
        busy     <= 1'b1;
        strikes  <= 2'd0;
        solved   <= 1'b0;
        exploded <= 1'b0;
        for (int i = 0; i < SEQ_LEN; i++) r_done[i] <= 1'b0;
      end else begin
        case (r_state)
          ST_GEN: begin
            if (is_symbol(w_sym)) begin
              r_type[r_idx] <= w_sym;
              r_done[r_idx] <= 1'b0;
              if (r_idx == LAST) begin
                r_state <= ST_PLAY;
                r_idx   <= '0;
                busy    <= 1'b0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          ST_PLAY: begin
            if (btn_valid) begin
              if (btn_code == r_type[r_idx]) begin
                r_done[r_idx] <= 1'b1;
                if (r_idx == LAST) begin
                  r_state <= ST_SOLVED;
                  solved  <= 1'b1;
                end else begin
                  r_idx <= r_idx + 1'b1;
                end
              end else begin
                strike <= 1'b1;
                r_idx  <= '0;
                for (int i = 0; i < SEQ_LEN; i++) r_done[i] <= 1'b0;
                if (strikes == 2'd2) begin
                  strikes  <= 2'd3;
                  r_state  <= ST_FAIL;
                  exploded <= 1'b1;
                end else begin
                  strikes <= strikes + 2'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/sequence_stage.md
SEQUENCE_STAGE -- requirements
Module: sequence_stage

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 8, number of symbol slots shown by the display.
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins or restarts a round.
REQ-006 SHALL have port btn_valid  input  1  one-cycle pulse; a debounced player press is present.
REQ-007 SHALL have port btn_code  input  3  pressed symbol (0 LEFT, 1 RIGHT, 2 UP, 3 DOWN, 4 A, 5 B); sampled only when btn_valid=1.
REQ-008 SHALL have port buttons  output  4 x SEQ_LEN (unpacked [0:SEQ_LEN-1])  per slot {done, type[2:0]}; feeds graphics_controller directly.
REQ-009 SHALL have port busy  output  1  high while the sequence is being generated.
REQ-010 SHALL have port strike  output  1  one-cycle pulse on a wrong press.
REQ-011 SHALL have port strikes  output  2  saturating count of wrong presses this round.
REQ-012 SHALL have port solved  output  1  level; high in SOLVED.
REQ-013 SHALL have port exploded  output  1  level; high in FAIL.

Function
REQ-014 SHALL implement states IDLE, GEN, PLAY, SOLVED, FAIL.
REQ-015 SHALL free-run a 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle in all states.
REQ-016 GEN: each cycle SHALL take LFSR[2:0]; if <6, write it to slot idx with done=0 and increment idx; if 6 or 7, discard it and keep idx.
REQ-017 SHALL transition GEN->PLAY in the cycle after slot SEQ_LEN-1 is written; idx reset to 0, busy low.
REQ-018 PLAY: btn_valid with btn_code==buttons[idx].type SHALL set buttons[idx].done=1 and idx+1, visible the next cycle.
REQ-019 PLAY: a correct press on slot SEQ_LEN-1 SHALL go to SOLVED.
REQ-020 PLAY: a wrong press SHALL pulse strike for exactly one cycle, clear all done bits, set idx=0 and increment strikes.
REQ-021 A wrong press that brings strikes to 3 SHALL go to FAIL; strikes SHALL hold at 3.
REQ-022 btn_valid SHALL be ignored in IDLE, GEN, SOLVED and FAIL.
REQ-023 start in any state SHALL enter GEN, clear strikes, zero idx and clear all done bits, with types rewritten as generated.
REQ-024 start and btn_valid in the same cycle SHALL resolve as start only.
REQ-025 btn_code values 6 and 7 in PLAY SHALL count as wrong presses.
REQ-026 All outputs SHALL be registered; buttons SHALL be unchanged in states other than GEN and PLAY.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, idx=0, LFSR=LFSR_SEED, every buttons slot=4'b0000, busy=0, strike=0, strikes=0, solved=0, exploded=0.
REQ-028 rst_n deasserted mid-GEN or mid-PLAY SHALL leave the block in IDLE; a new start is required to begin a round.

Structure
REQ-029 Package bomb_pkg SHALL hold the symbol code constants (LEFT..B), the state enum and the default SEQ_LEN.
REQ-030 The LFSR SHALL be a sub-module lfsr16 with ports clk, rst_n, seed and q[15:0].
REQ-031 The RTL SHALL be synthesizable, contain no latches, and use no clock other than clk.

Verification
REQ-032 Reset then start -> busy=1 for at least 8 cycles; then every slot type is <=5, every done=0, state PLAY; the slot sequence matches a reference-model LFSR from 16'hACE1.
REQ-033 PLAY, press all 8 correct codes on consecutive cycles -> done bits set 1..8 in order; solved=1 the cycle after the 8th press; strike never pulses.
REQ-034 PLAY, 3 correct presses then a wrong code -> strike pulses 1 cycle, strikes=1, buttons[0..2].done back to 0, next correct press marks slot 0.
REQ-035 Three wrong presses -> strikes=3, exploded=1; further btn_valid leaves buttons unchanged; start -> GEN, strikes=0, exploded=0.
REQ-036 start together with a correct btn_valid in PLAY -> regenerate and no done bit set; btn_code=7 in PLAY -> counted as a strike.
REQ-037 Assert rst_n low mid-GEN (idx=4) -> all outputs take reset values immediately, before the next clk edge.
